unsigned_div_16by8_seq: RTL and testbench

Sequential restoring divider that inverts the 8x8 unsigned multiplier datapath: it takes a 16-bit product-domain value z and an 8-bit operand y and recovers the 8-bit quotient x and 8-bit remainder (z = x*y + r). It sits downstream of the approximate multipliers in the error-evaluation and characterisation path. It uses valid/ready handshakes on both sides and produces one bit of quotient per clock.

---
 rtl/unsigned_div_16by8_seq.sv | 155 +++++++++++++++
 tb/tb_unsigned_div_16by8_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/unsigned_div_16by8_seq.sv
// unsigned_div_16by8_seq
// Sequential restoring divider: recovers quotient q and remainder r from a
// 16-bit product-domain value z and an 8-bit operand y (z = q*y + r),
// producing one quotient bit per clock.
//
// Optional feature macro: UDIV_APPROX_TRUNC_EN
//   defined     -> z[TRUNC_L-1:0] is zeroed at accept (approximate build)
//   not defined -> full z is used (exact division); TRUNC_L has no effect
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   divider can accept an operand pair (IDLE only)
//   z          16-bit unsigned dividend
//   y          8-bit unsigned divisor
//   out_valid  q/r/dz/ovf valid, held until out_ready
//   out_ready  consumer accepts the result
//   q          8-bit quotient (8'hFF on exception)
//   r          8-bit remainder (8'hFF on exception)
//   dz         divide-by-zero flag
//   ovf        quotient overflow flag (z[15:8] >= y, y != 0)
module unsigned_div_16by8_seq #(
  parameter int TRUNC_L = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] z,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  q,
  output logic [7:0]  r,
  output logic        dz,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef UDIV_APPROX_TRUNC_EN
  localparam logic [15:0] TRUNC_MASK = 16'hFFFF << TRUNC_L;
`else
  // All-ones mask: TRUNC_L has no effect in the exact build.
  localparam logic [15:0] TRUNC_MASK = 16'hFFFF | (16'hFFFF << TRUNC_L);
`endif

  state_t      state_reg, state_next;
  logic [8:0]  rem_reg;
  logic [7:0]  dvd_reg;
  logic [7:0]  quo_reg;
  logic [7:0]  y_reg;
  logic [2:0]  cnt_reg;
  logic        dz_res_reg, ovf_res_reg;
  logic [7:0]  q_reg, r_reg;
  logic        dz_reg, ovf_reg, out_valid_reg;

  logic        accept, handshake;
  logic [15:0] z_eff;
  logic        is_dz, is_ovf;
  logic [8:0]  rem_shift, rem_sub;
  logic        bit_set;

  assign accept    = in_valid && (state_reg == IDLE);
  assign handshake = out_valid_reg && out_ready;
  assign z_eff     = z & TRUNC_MASK;
  assign is_dz     = (y == 8'h00);
  assign is_ovf    = !is_dz && (z_eff[15:8] >= y);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign rem_shift = {rem_reg[7:0], dvd_reg[7]};
  assign rem_sub   = rem_shift - {1'b0, y_reg};
  assign bit_set   = (rem_shift >= {1'b0, y_reg});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = (is_dz || is_ovf) ? DONE : BUSY;
      BUSY: if (cnt_reg == 3'd7) state_next = DONE;
      DONE: if (handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_reg == IDLE);
    out_valid = out_valid_reg;
    q         = q_reg;
    r         = r_reg;
    dz        = dz_reg;
    ovf       = ovf_reg;
  end

  // Division datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg     <= '0;
      dvd_reg     <= '0;
      quo_reg     <= '0;
      y_reg       <= '0;
      cnt_reg     <= '0;
      dz_res_reg  <= 1'b0;
      ovf_res_reg <= 1'b0;
    end else if (accept) begin
      y_reg       <= y;
      cnt_reg     <= '0;
      dz_res_reg  <= is_dz;
      ovf_res_reg <= is_ovf;
      if (is_dz || is_ovf) begin
        quo_reg <= 8'hFF;
        rem_reg <= 9'h0FF;
        dvd_reg <= '0;
      end else begin
        quo_reg <= '0;
        rem_reg <= {1'b0, z_eff[15:8]};
        dvd_reg <= z_eff[7:0];
      end
    end else if (state_reg == BUSY) begin
      rem_reg <= bit_set ? rem_sub : rem_shift;
      quo_reg <= {quo_reg[6:0], bit_set};
      dvd_reg <= {dvd_reg[6:0], 1'b0};
      cnt_reg <= cnt_reg + 3'd1;
    end
  end

  // Result registers: loaded on the first DONE cycle, so out_valid trails
  // entry into DONE by one clock and the fields stay frozen until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      q_reg         <= '0;
      r_reg         <= '0;
      dz_reg        <= 1'b0;
      ovf_reg       <= 1'b0;
    end else if ((state_reg == DONE) && !out_valid_reg) begin
      out_valid_reg <= 1'b1;
      q_reg         <= quo_reg;
      r_reg         <= rem_reg[7:0];
      dz_reg        <= dz_res_reg;
      ovf_reg       <= ovf_res_reg && !dz_res_reg;
    end else if (handshake) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unsigned_div_16by8_seq.sv
// Self-checking bench for unsigned_div_16by8_seq: vector table plus
// hand-written backpressure, early out_ready and mid-operation reset sequences.
module tb_unsigned_div_16by8_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] z;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        dz;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef UDIV_APPROX_TRUNC_EN
  localparam bit TRUNC = 1'b1;
`else
  localparam bit TRUNC = 1'b0;
`endif

  unsigned_div_16by8_seq #(.TRUNC_L(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .r         (r),
    .dz        (dz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic [7:0]  y;
    logic [7:0]  q;    // exact build
    logic [7:0]  r;
    logic [7:0]  qt;   // truncated build (TRUNC_L = 6)
    logic [7:0]  rt;
    logic        dz;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic start_op(input logic [15:0] zi, input logic [7:0] yi);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_before_accept", {15'd0, in_ready}, 16'd1);
    z = zi; y = yi; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_handshake", {15'd0, out_valid}, 16'd0);
    check("in_ready_after_handshake", {15'd0, in_ready}, 16'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] eq, er;

    vecs[0] = '{16'h3039, 8'h64, 8'h7B, 8'h2D, 8'h7A, 8'h58, 1'b0, 1'b0, 9};
    vecs[1] = '{16'hFE01, 8'hFF, 8'hFF, 8'h00, 8'hFE, 8'hFE, 1'b0, 1'b0, 9};
    vecs[2] = '{16'h0000, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 9};
    vecs[3] = '{16'h1234, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1};
    vecs[4] = '{16'hFFFF, 8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1};
    vecs[5] = '{16'h0A00, 8'h0A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1};
    vecs[6] = '{16'h09FF, 8'h0A, 8'hFF, 8'h09, 8'hF9, 8'h06, 1'b0, 1'b0, 9};
    vecs[7] = '{16'h7FFF, 8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h40, 1'b0, 1'b0, 9};
    vecs[8] = '{16'h00FF, 8'h01, 8'hFF, 8'h00, 8'hC0, 8'h00, 1'b0, 1'b0, 9};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; z = '0; y = '0;
    #1;
    check("reset_out_valid", {15'd0, out_valid}, 16'd0);
    check("reset_q", {8'd0, q}, 16'd0);
    check("reset_r", {8'd0, r}, 16'd0);
    check("reset_dz", {15'd0, dz}, 16'd0);
    check("reset_ovf", {15'd0, ovf}, 16'd0);
    check("reset_in_ready", {15'd0, in_ready}, 16'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < 9; i++) begin
      eq = TRUNC ? vecs[i].qt : vecs[i].q;
      er = TRUNC ? vecs[i].rt : vecs[i].r;
      start_op(vecs[i].z, vecs[i].y);
      check("in_ready_low_after_accept", {15'd0, in_ready}, 16'd0);
      wait_valid(lat);
      $display("vec %0d z=%h y=%h -> q=%h r=%h dz=%b ovf=%b lat=%0d", i,
               vecs[i].z, vecs[i].y, q, r, dz, ovf, lat);
      check("latency", lat[15:0], vecs[i].lat[15:0]);
      check("q", {8'd0, q}, {8'd0, eq});
      check("r", {8'd0, r}, {8'd0, er});
      check("dz", {15'd0, dz}, {15'd0, vecs[i].dz});
      check("ovf", {15'd0, ovf}, {15'd0, vecs[i].ovf});
      check("in_ready_low_in_done", {15'd0, in_ready}, 16'd0);
      consume();
    end

    // Backpressure: hold result 20 cycles while foreign inputs are offered
    eq = TRUNC ? 8'h7A : 8'h7B;
    er = TRUNC ? 8'h58 : 8'h2D;
    start_op(16'h3039, 8'h64);
    wait_valid(lat);
    check("bp_latency", lat[15:0], 16'd9);
    z = 16'hFFFF; y = 8'h00; in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {15'd0, out_valid}, 16'd1);
      check("bp_in_ready", {15'd0, in_ready}, 16'd0);
      check("bp_q", {8'd0, q}, {8'd0, eq});
      check("bp_r", {8'd0, r}, {8'd0, er});
      check("bp_flags", {14'd0, dz, ovf}, 16'd0);
    end
    in_valid = 1'b0;
    $display("backpressure q=%h r=%h held 20 cycles", q, r);
    consume();

    // out_ready already high before out_valid: single-cycle handshake
    out_ready = 1'b1;
    start_op(16'h0064, 8'h0A);
    wait_valid(lat);
    $display("early_ready z=0064 y=0a -> q=%h r=%h lat=%0d", q, r, lat);
    check("early_latency", lat[15:0], 16'd9);
    check("early_q", {8'd0, q}, TRUNC ? 16'h0006 : 16'h000A);
    check("early_r", {8'd0, r}, TRUNC ? 16'h0004 : 16'h0000);
    @(posedge clk); #1;
    check("early_consumed", {15'd0, out_valid}, 16'd0);
    check("early_in_ready", {15'd0, in_ready}, 16'd1);
    out_ready = 1'b0;

    // Reset during BUSY step 4, then a clean operation
    start_op(16'hFE01, 8'hFF);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {15'd0, out_valid}, 16'd0);
    check("midrst_in_ready", {15'd0, in_ready}, 16'd1);
    check("midrst_q", {8'd0, q}, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check("midrst_no_result", {15'd0, out_valid}, 16'd0);
    end
    $display("reset mid-BUSY: out_valid=%b in_ready=%b", out_valid, in_ready);
    start_op(16'h0064, 8'h0A);
    wait_valid(lat);
    $display("post_reset z=0064 y=0a -> q=%h r=%h lat=%0d", q, r, lat);
    check("post_rst_latency", lat[15:0], 16'd9);
    check("post_rst_q", {8'd0, q}, TRUNC ? 16'h0006 : 16'h000A);
    check("post_rst_r", {8'd0, r}, TRUNC ? 16'h0004 : 16'h0000);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
